// File: rtl/mem_block_responder_pkg.sv
// Shared constants, FSM encoding and miss-fill helper for the block memory
// responder and the cache that talks to it.
package mem_block_responder_pkg;

    localparam int BLOCK_BITS   = 256;
    localparam int ADDR_BITS    = 32;
    localparam int OFFSET_BITS  = 5;
    localparam int BLKADDR_BITS = ADDR_BITS - OFFSET_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Unwritten blocks read back as their own block address, once per word.
    function automatic logic [BLOCK_BITS-1:0] miss_fill(input logic [BLKADDR_BITS-1:0] blk);
        return {(BLOCK_BITS / ADDR_BITS){blk, {OFFSET_BITS{1'b0}}}};
    endfunction

endpackage

// File: rtl/mem_block_array.sv
// Block storage: one synchronous write port, one combinational read port,
// per-block valid bits. Data contents are never reset.
module mem_block_array
    import mem_block_responder_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] waddr,
    input  logic [BLOCK_BITS-1:0] wdata,
    input  logic [INDEX_BITS-1:0] raddr,
    output logic [BLOCK_BITS-1:0] rdata,
    output logic                  rvalid
);

    localparam int DEPTH = 1 << INDEX_BITS;

    logic [BLOCK_BITS-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      valid;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid <= '0;
        end else if (we) begin
            valid[waddr] <= 1'b1;
        end
    end

    assign rdata  = mem[raddr];
    assign rvalid = valid[raddr];

endmodule

// File: rtl/mem_block_responder.sv
// Fixed-latency block memory responder: accepts one block read/write request,
// answers LATENCY cycles later and holds the response until consumed.
module mem_block_responder
    import mem_block_responder_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_BITS-1:0]  req_addr,
    input  logic [BLOCK_BITS-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_write,
    output logic [BLOCK_BITS-1:0] resp_rdata
);

    state_t                  state;
    logic [3:0]              cnt;
    logic                    cap_write;
    logic [BLKADDR_BITS-1:0] cap_blk;
    logic [BLOCK_BITS-1:0]   cap_wdata;
    logic [INDEX_BITS-1:0]   idx;
    logic [BLOCK_BITS-1:0]   arr_rdata;
    logic                    arr_rvalid;
    logic                    commit;
    logic                    unused_addr_offset;

    assign unused_addr_offset = ^req_addr[OFFSET_BITS-1:0];
    assign idx = cap_blk[INDEX_BITS-1:0];

    // Writes land only on the BUSY->RESP edge, and never on a reset edge.
    assign commit = reset && (state == ST_BUSY) && (cnt == '0) && cap_write;

    mem_block_array #(
        .INDEX_BITS(INDEX_BITS)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (commit),
        .waddr (idx),
        .wdata (cap_wdata),
        .raddr (idx),
        .rdata (arr_rdata),
        .rvalid(arr_rvalid)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_write <= 1'b0;
            resp_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        cap_write <= req_write;
                        cap_blk   <= req_addr[ADDR_BITS-1:OFFSET_BITS];
                        cap_wdata <= req_wdata;
                        cnt       <= 4'(LATENCY - 1);
                        req_ready <= 1'b0;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_write <= cap_write;
                        if (cap_write) begin
                            resp_rdata <= '0;
                        end else if (arr_rvalid) begin
                            resp_rdata <= arr_rdata;
                        end else begin
                            resp_rdata <= miss_fill(cap_blk);
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_block_responder.sv
// Scoreboard bench for mem_block_responder: a bench-side block model predicts
// each response at request time; a monitor pops and compares on handshake.
module tb_mem_block_responder;

    localparam int LAT = 4;
    localparam int IB  = 6;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_write = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [255:0] req_wdata = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic         resp_write;
    logic [255:0] resp_rdata;

    mem_block_responder #(
        .LATENCY   (LAT),
        .INDEX_BITS(IB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_write(resp_write),
        .resp_rdata(resp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         w;
        logic [255:0] d;
    } exp_t;

    exp_t         exp_q[$];
    int           acc_q[$];
    int           acc_hist[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_errors = 0;
    bit           mvalid [64];
    logic [255:0] mdata [64];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic junk();
        req_write = 1'($urandom_range(0, 1));
        req_addr  = $urandom();
        for (int i = 0; i < 8; i++) req_wdata[i*32 +: 32] = $urandom();
    endtask

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [255:0] d,
                         input bit track, input bit keep);
        int           n;
        logic [5:0]   ix;
        logic [31:0]  fill;
        exp_t         e;
        n = 0;
        req_valid = 1'b1;
        while (!req_ready && n < 100) begin
            junk();
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        if (track) begin
            ix   = a[10:5];
            fill = {a[31:5], 5'b0};
            e.w  = w;
            if (w) e.d = '0;
            else if (mvalid[ix]) e.d = mdata[ix];
            else e.d = {8{fill}};
            exp_q.push_back(e);
            if (w) begin
                mvalid[ix] = 1'b1;
                mdata[ix]  = d;
            end
        end
        @(negedge clk);
        if (keep) junk();
        else req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && req_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("idle_timeout", 0, 1);
    endtask

    task automatic reset_model();
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    endtask

    // Monitor samples just after the falling edge, once inputs have settled.
    logic         prev_rv = 1'b0;
    logic         prev_rr = 1'b0;
    logic         prev_rw = 1'b0;
    logic [255:0] prev_rd = '0;

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!reset) begin
            acc_q.delete();
        end else begin
            if (req_valid && req_ready) begin
                acc_q.push_back(cyc);
                acc_hist.push_back(cyc);
            end
            if (resp_valid && !prev_rv) begin
                if (acc_q.size() == 0) check("latency_noacc", 0, 1);
                else check("latency", 256'(cyc - acc_q.pop_front() - 1), 256'(LAT));
            end
            if (resp_valid) check("ready_in_resp", req_ready, 0);
            if (prev_rv && !prev_rr) begin
                check("hold_valid", resp_valid, 1);
                check("hold_rdata", resp_rdata, prev_rd);
                check("hold_write", resp_write, prev_rw);
            end
            if (prev_rv && prev_rr) begin
                check("idle_after_hs", req_ready, 1);
                check("valid_drop", resp_valid, 0);
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_write", resp_write, e.w);
                    check("resp_rdata", resp_rdata, e.d);
                end
            end
        end
        prev_rv = resp_valid && reset;
        prev_rr = resp_ready;
        prev_rw = resp_write;
        prev_rd = resp_rdata;
    end

    initial begin
        int          n;
        logic [31:0] a;
        logic [255:0] d;
        logic        w;

        reset_model();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_write", resp_write, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_reset", req_ready, 1);

        // Unwritten read, aligned write/read with ignored offset, aliasing.
        issue(1'b0, 32'h9876ABC0, '0, 1, 0);
        wait_idle();
        issue(1'b1, 32'hABCDABC0, 256'h123456, 1, 0);
        wait_idle();
        issue(1'b0, 32'hABCDABD5, '0, 1, 0);
        wait_idle();
        issue(1'b1, 32'h12345678, 256'h666666, 1, 0);
        wait_idle();
        issue(1'b0, 32'h00000678, '0, 1, 0);
        wait_idle();

        // Response back-pressure for three cycles.
        resp_ready = 1'b0;
        issue(1'b0, 32'h12345678, '0, 1, 0);
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_resp_seen", resp_valid, 1);
        repeat (3) @(negedge clk);
        resp_ready = 1'b1;
        wait_idle();

        // Reset during the second BUSY cycle discards the write.
        issue(1'b1, 32'h00000040, {8{32'hDEADBEEF}}, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        reset_model();
        @(negedge clk);
        check("rst2_resp_valid", resp_valid, 0);
        check("rst2_req_ready", req_ready, 0);
        reset = 1'b1;
        issue(1'b0, 32'h00000040, '0, 1, 0);
        wait_idle();

        // Back-to-back reads, req_valid held high with junk while busy.
        acc_hist.delete();
        issue(1'b0, 32'h00001000, '0, 1, 1);
        issue(1'b0, 32'h00000678, '0, 1, 1);
        issue(1'b0, 32'hABCDABC0, '0, 1, 0);
        wait_idle();
        if (acc_hist.size() != 3) begin
            check("b2b_count", 256'(acc_hist.size()), 3);
        end else begin
            check("b2b_gap1", 256'(acc_hist[1] - acc_hist[0]), 256'(LAT + 2));
            check("b2b_gap2", 256'(acc_hist[2] - acc_hist[1]), 256'(LAT + 2));
        end

        // Random mix over a few indices.
        for (int k = 0; k < 12; k++) begin
            w = 1'($urandom_range(0, 1));
            a = $urandom();
            a[10:5] = 6'($urandom_range(1, 3));
            for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();
            issue(w, a, d, 1, 0);
            wait_idle();
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 256'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_block_responder.md
MEM_BLOCK_RESPONDER -- requirements
Module: mem_block_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, cycles from request acceptance to resp_valid (legal range 1..15).
REQ-002 SHALL have parameter INDEX_BITS, default 6, log2 of the number of 256-bit blocks stored (64).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  cache presents a block request.
REQ-006 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = block write-back, 0 = block refill read.
REQ-008 SHALL have port req_addr  input  32  physical address; bits [4:0] ignored.
REQ-009 SHALL have port req_wdata  input  256  write-back block.
REQ-010 SHALL have port resp_valid  output  1  response present.
REQ-011 SHALL have port resp_ready  input  1  cache consumes the response.
REQ-012 SHALL have port resp_write  output  1  echo of req_write for the response.
REQ-013 SHALL have port resp_rdata  output  256  refill block (all zero for write responses).

Function
REQ-014 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE; req_ready = 1 only in IDLE.
REQ-015 SHALL accept on req_valid && req_ready; capture req_write, req_addr[31:5], req_wdata; go to BUSY.
REQ-016 SHALL load a down-counter with LATENCY-1 on acceptance, decrement each BUSY cycle, enter RESP when the counter reaches 0, so that resp_valid rises exactly LATENCY cycles after the acceptance edge.
REQ-017 SHALL use block index = captured address bits [INDEX_BITS+4:5]; upper address bits are not stored (no tags; aliasing addresses share a block).
REQ-018 SHALL keep one valid bit per block; a write commits data and sets the valid bit on the BUSY->RESP transition, not earlier.
REQ-019 Read of a valid block SHALL return the stored data; read of an invalid block SHALL return {8{captured_addr[31:5], 5'b0}}.
REQ-020 SHALL hold resp_valid, resp_write, and resp_rdata stable in RESP until resp_ready = 1; on that edge, go to IDLE.
REQ-021 SHALL assert req_ready no earlier than the cycle after the response handshake; back-to-back throughput is one request per LATENCY+2 cycles with resp_ready held high.
REQ-022 A read request issued after a write response to the same index SHALL return the newly written data.
REQ-023 SHALL ignore req_* while not in IDLE; resp_ready outside RESP SHALL have no effect.

Reset
REQ-024 When reset = 0 at a clock edge, SHALL set state IDLE, counter 0, all valid bits 0, req_ready 0 during reset, resp_valid 0, resp_write 0, and resp_rdata 0.
REQ-025 Reset in BUSY or RESP SHALL abandon the transaction; an uncommitted write SHALL NOT reach the array.
REQ-026 SHALL NOT reset the data array contents; valid bits alone define readback.
REQ-027 SHALL assert req_ready in the first cycle after reset deasserts.

Structure
REQ-028 Shared package SHALL hold BLOCK_BITS = 256, ADDR_BITS = 32, OFFSET_BITS = 5, and the FSM state encoding, reused by the cache block.
REQ-029 The data array plus valid bits SHALL be one sub-module, mem_block_array (one write port, one read port, synchronous write).

Verification
REQ-030 Read of unwritten address 0x9876ABC0 after reset -> resp_valid exactly 4 cycles after acceptance, resp_rdata = {8{32'h9876ABC0}}, resp_write = 0.
REQ-031 Write of 256'h123456 to 0xABCDABC0, then read 0xABCDABD5 -> write response with resp_write = 1 and rdata 0; read returns 256'h123456.
REQ-032 Write of 256'h666666 to 0x12345678, then read 0x00000678 (same index 51) -> returns 256'h666666 (alias).
REQ-033 Read response with resp_ready held low for 3 cycles -> resp_valid and resp_rdata stable, req_ready = 0 throughout, and IDLE is entered the cycle after resp_ready = 1.
REQ-034 Write to 0x00000040 with reset pulsed low in the 2nd BUSY cycle, then read 0x00000040 -> returns {8{32'h00000040}} (write discarded).
REQ-035 req_valid held high continuously for 3 reads with resp_ready = 1 -> acceptances spaced exactly 6 cycles apart, and req_* changes while busy are ignored.
